// File: rtl/xing_pkg.sv
// rtl/xing_pkg.sv - shared state encodings, default dwells and light vectors for the junction scheduler
package xing_pkg;

  // Phase encodings, also exported on the debug phase port
  typedef enum logic [2:0] {
    ST_J_GRN  = 3'd0,
    ST_J_YEL  = 3'd1,
    ST_AR_IN  = 3'd2,
    ST_C_GRN  = 3'd3,
    ST_C_YEL  = 3'd4,
    ST_P_WLK  = 3'd5,
    ST_AR_OUT = 3'd6
  } phase_t;

  // Default dwell times in ticks (seconds)
  localparam int DEF_J_MIN  = 20;
  localparam int DEF_C_GRN  = 10;
  localparam int DEF_P_WALK = 8;
  localparam int DEF_Y_T    = 3;
  localparam int DEF_AR_T   = 1;
  localparam int DEF_TW     = 6;

  // Light vectors, bit order {Jg,Jy,Jr,Cg,Cy,Cr,Pg,Pr}
  localparam logic [7:0] LT_J_GRN = 8'b1000_0101;
  localparam logic [7:0] LT_J_YEL = 8'b0100_0101;
  localparam logic [7:0] LT_ALLRD = 8'b0010_0101;
  localparam logic [7:0] LT_C_GRN = 8'b0011_0001;
  localparam logic [7:0] LT_C_YEL = 8'b0010_1001;
  localparam logic [7:0] LT_P_WLK = 8'b0010_0110;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with zero flag, saturating at zero
module phase_timer #(
  parameter int            TW      = 6,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count;

  // Load wins; otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/xing_phase_sched.sv
// rtl/xing_phase_sched.sv - junction phase sequencer with request latches and round-robin arbitration
module xing_phase_sched
  import xing_pkg::*;
#(
  parameter int J_MIN  = DEF_J_MIN,
  parameter int C_GRN  = DEF_C_GRN,
  parameter int P_WALK = DEF_P_WALK,
  parameter int Y_T    = DEF_Y_T,
  parameter int AR_T   = DEF_AR_T,
  parameter int TW     = DEF_TW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c_req,
  input  logic       p_req,
  output logic       Jg,
  output logic       Jy,
  output logic       Jr,
  output logic       Cg,
  output logic       Cy,
  output logic       Cr,
  output logic       Pg,
  output logic       Pr,
  output logic       c_pend,
  output logic       p_pend,
  output logic [2:0] phase
);

  phase_t        state;
  phase_t        nxt;
  logic          load;
  logic          force_ld;
  logic [TW-1:0] load_val;
  logic          tzero;
  logic          serve_p;
  logic          serve_c;
  logic          rr;
  logic [7:0]    light;

  phase_timer #(
    .TW      (TW),
    .RST_VAL (TW'(J_MIN - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (tzero)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_J_GRN;
    end else begin
      state <= nxt;
    end
  end

  // Next-state, service selection and timer reload value
  always_comb begin
    nxt      = state;
    force_ld = 1'b0;
    serve_p  = 1'b0;
    serve_c  = 1'b0;
    load_val = TW'(J_MIN - 1);
    case (state)
      ST_J_GRN:  if (tzero && (c_pend || p_pend)) nxt = ST_J_YEL;
      ST_J_YEL:  if (tzero) nxt = ST_AR_IN;
      ST_AR_IN: begin
        if (tzero) begin
          // rr=0 lets the pedestrian win a tie
          if (p_pend && (!c_pend || !rr)) begin
            nxt     = ST_P_WLK;
            serve_p = 1'b1;
          end else if (c_pend) begin
            nxt     = ST_C_GRN;
            serve_c = 1'b1;
          end else begin
            nxt = ST_J_GRN;
          end
        end
      end
      ST_C_GRN:  if (tzero) nxt = ST_C_YEL;
      ST_C_YEL:  if (tzero) nxt = ST_AR_OUT;
      ST_P_WLK:  if (tzero) nxt = ST_AR_OUT;
      ST_AR_OUT: if (tzero) nxt = ST_J_GRN;
      default: begin
        nxt      = ST_J_GRN;
        force_ld = 1'b1;
      end
    endcase
    case (nxt)
      ST_J_YEL, ST_C_YEL:  load_val = TW'(Y_T - 1);
      ST_AR_IN, ST_AR_OUT: load_val = TW'(AR_T - 1);
      ST_C_GRN:            load_val = TW'(C_GRN - 1);
      ST_P_WLK:            load_val = TW'(P_WALK - 1);
      default:             load_val = TW'(J_MIN - 1);
    endcase
    load = (nxt != state) || force_ld;
  end

  // Request latches and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_pend <= 1'b0;
      c_pend <= 1'b0;
      rr     <= 1'b0;
    end else begin
      if (serve_p) begin
        p_pend <= 1'b0;
      end else if (p_req && (state != ST_P_WLK)) begin
        p_pend <= 1'b1;
      end
      if (serve_c) begin
        c_pend <= 1'b0;
      end else if (c_req && (state != ST_C_GRN) && (state != ST_C_YEL)) begin
        c_pend <= 1'b1;
      end
      if (serve_p) begin
        rr <= 1'b1;
      end else if (serve_c) begin
        rr <= 1'b0;
      end
    end
  end

  // Moore light decode; an illegal encoding shows main-road green
  always_comb begin
    light = LT_J_GRN;
    case (state)
      ST_J_GRN:            light = LT_J_GRN;
      ST_J_YEL:            light = LT_J_YEL;
      ST_AR_IN, ST_AR_OUT: light = LT_ALLRD;
      ST_C_GRN:            light = LT_C_GRN;
      ST_C_YEL:            light = LT_C_YEL;
      ST_P_WLK:            light = LT_P_WLK;
      default:             light = LT_J_GRN;
    endcase
  end

  assign {Jg, Jy, Jr, Cg, Cy, Cr, Pg, Pr} = light;
  assign phase = state;

endmodule

// File: tb/tb_xing_phase_sched.sv
// tb/tb_xing_phase_sched.sv - randomized and directed check of the junction scheduler against a behavioural model
module tb_xing_phase_sched;

  logic       clk;
  logic       rst;
  logic       c_req;
  logic       p_req;
  logic       Jg, Jy, Jr, Cg, Cy, Cr, Pg, Pr;
  logic       c_pend, p_pend;
  logic [2:0] phase;

  int n_checks;
  int n_fail;
  int edge_n;

  // model state: phase number, edges spent in it, latches, tie pointer
  int m_ph;
  int m_el;
  int m_p;
  int m_c;
  int m_rr;

  xing_phase_sched dut (
    .clk    (clk),
    .rst    (rst),
    .c_req  (c_req),
    .p_req  (p_req),
    .Jg     (Jg),
    .Jy     (Jy),
    .Jr     (Jr),
    .Cg     (Cg),
    .Cy     (Cy),
    .Cr     (Cr),
    .Pg     (Pg),
    .Pr     (Pr),
    .c_pend (c_pend),
    .p_pend (p_pend),
    .phase  (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int dwell(input int ph);
    case (ph)
      0:       return 20;
      1, 4:    return 3;
      2, 6:    return 1;
      3:       return 10;
      5:       return 8;
      default: return 1;
    endcase
  endfunction

  // head colour: 0 green/walk, 1 yellow, 2 red/don't-walk
  function automatic logic [7:0] lights_of(input int ph);
    int j, c, p;
    j = (ph == 0) ? 0 : (ph == 1) ? 1 : 2;
    c = (ph == 3) ? 0 : (ph == 4) ? 1 : 2;
    p = (ph == 5) ? 0 : 2;
    return {j == 0, j == 1, j == 2, c == 0, c == 1, c == 2, p == 0, p == 2};
  endfunction

  // model advance on every edge, then compare all outputs shortly after
  initial begin
    int  np, sp, sc;
    bit  done;
    m_ph = 0; m_el = 0; m_p = 0; m_c = 0; m_rr = 0; edge_n = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ph = 0; m_el = 0; m_p = 0; m_c = 0; m_rr = 0; edge_n = 0;
      end else begin
        edge_n++;
        done = (m_el + 1 >= dwell(m_ph));
        np = m_ph; sp = 0; sc = 0;
        if (done) begin
          case (m_ph)
            0: if (m_c != 0 || m_p != 0) np = 1;
            1: np = 2;
            2: begin
              if (m_p != 0 && m_c != 0) begin
                if (m_rr == 0) sp = 1; else sc = 1;
              end else if (m_p != 0) sp = 1;
              else if (m_c != 0) sc = 1;
              np = sp ? 5 : sc ? 3 : 0;
            end
            3: np = 4;
            4: np = 6;
            5: np = 6;
            default: np = 0;
          endcase
        end
        if (sp != 0) m_p = 0; else if (p_req && m_ph != 5) m_p = 1;
        if (sc != 0) m_c = 0; else if (c_req && m_ph != 3 && m_ph != 4) m_c = 1;
        if (sp != 0) m_rr = 1; else if (sc != 0) m_rr = 0;
        if (np != m_ph) m_el = 0; else if (m_el < 1000) m_el++;
        m_ph = np;
      end
      #1;
      check("phase", 32'(phase), 32'(m_ph));
      check("lights", 32'({Jg, Jy, Jr, Cg, Cy, Cr, Pg, Pr}), 32'(lights_of(m_ph)));
      check("pends", 32'({c_pend, p_pend}), 32'({m_c[0], m_p[0]}));
      check("one_hot", 32'({$onehot({Jg, Jy, Jr}), $onehot({Cg, Cy, Cr}), $onehot({Pg, Pr})}), 32'h7);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; c_req = 1'b0; p_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected end before 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; c_req = 1'b0; p_req = 1'b0;

    // idle: main road rests in green
    do_reset();
    check("rst_lights", 32'({Jg, Jy, Jr, Cg, Cy, Cr, Pg, Pr}), 32'h85);
    check("rst_phase", 32'(phase), 32'd0);
    wait_edge(100);
    check("idle100_phase", 32'(phase), 32'd0);

    // single pedestrian pulse at cycle 5
    do_reset();
    wait_edge(4); p_req = 1'b1;
    wait_edge(5); p_req = 1'b0;
    check("p5_pend", 32'(p_pend), 32'd1);
    wait_edge(19); check("p19_phase", 32'(phase), 32'd0);
    wait_edge(20); check("p20_phase", 32'(phase), 32'd1);
    wait_edge(23); check("p23_phase", 32'(phase), 32'd2);
    wait_edge(24); check("p24_phase", 32'(phase), 32'd5);
    check("p24_pend", 32'(p_pend), 32'd0);
    check("p24_walk", 32'({Pg, Jr}), 32'h3);
    wait_edge(31); check("p31_phase", 32'(phase), 32'd5);
    wait_edge(32); check("p32_phase", 32'(phase), 32'd6);
    wait_edge(33); check("p33_phase", 32'(phase), 32'd0);

    // cross-road request held from cycle 2
    do_reset();
    wait_edge(1); c_req = 1'b1;
    wait_edge(24); check("c24_phase", 32'(phase), 32'd3);
    wait_edge(30); check("c30_pend", 32'(c_pend), 32'd0);
    wait_edge(33); check("c33_phase", 32'(phase), 32'd3);
    wait_edge(34); check("c34_phase", 32'(phase), 32'd4);
    wait_edge(36); check("c36_phase", 32'(phase), 32'd4);
    wait_edge(37); check("c37_phase", 32'(phase), 32'd6);
    wait_edge(38); check("c38_phase", 32'(phase), 32'd0);
    wait_edge(57); check("c57_phase", 32'(phase), 32'd0);
    wait_edge(58); check("c58_phase", 32'(phase), 32'd1);
    c_req = 1'b0;

    // tie at cycle 3 goes to P, a tie later goes to C
    do_reset();
    wait_edge(2); c_req = 1'b1; p_req = 1'b1;
    wait_edge(3); c_req = 1'b0; p_req = 1'b0;
    wait_edge(24); check("rr24_phase", 32'(phase), 32'd5);
    check("rr24_cpend", 32'(c_pend), 32'd1);
    wait_edge(39); c_req = 1'b1; p_req = 1'b1;
    wait_edge(40); c_req = 1'b0; p_req = 1'b0;
    wait_edge(53); check("rr53_phase", 32'(phase), 32'd1);
    wait_edge(57); check("rr57_phase", 32'(phase), 32'd3);
    check("rr57_ppend", 32'(p_pend), 32'd1);
    wait_edge(95); check("rr95_phase", 32'(phase), 32'd5);

    // late request after a long idle green leaves at the next edge
    do_reset();
    wait_edge(44); p_req = 1'b1;
    wait_edge(45); p_req = 1'b0;
    check("late45_phase", 32'(phase), 32'd0);
    check("late45_pend", 32'(p_pend), 32'd1);
    wait_edge(46); check("late46_phase", 32'(phase), 32'd1);

    // asynchronous reset in the middle of the walk
    do_reset();
    wait_edge(4); p_req = 1'b1;
    wait_edge(5); p_req = 1'b0;
    wait_edge(26);
    check("mid_walk", 32'(phase), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("async_lights", 32'({Jg, Jy, Jr, Cg, Cy, Cr, Pg, Pr}), 32'h85);
    check("async_pends", 32'({c_pend, p_pend}), 32'd0);
    check("async_phase", 32'(phase), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_edge(1); p_req = 1'b1;
    wait_edge(2); p_req = 1'b0;
    wait_edge(19); check("post19_phase", 32'(phase), 32'd0);
    wait_edge(20); check("post20_phase", 32'(phase), 32'd1);

    // random traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        if ($urandom_range(0, 1) == 1) #2;
        rst = 1'b1;
        hold = $urandom_range(1, 3);
        repeat (hold) @(negedge clk);
        rst = 1'b0;
      end
      c_req = ($urandom_range(0, 24) == 0);
      p_req = ($urandom_range(0, 29) == 0);
    end
    c_req = 1'b0; p_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
